id_exe_stage: RTL and testbench
===============================

Name: id_exe_stage

Overview:
- Pipeline register between the ID stage and EXE, plus the execute datapath.
- Latches decoded control and operands from ID, applies MEM/WB operand forwarding, and computes ALU results.
- Runs an iterative shift-add multiplier that stalls the front end while busy.
- Drives the registered EXE/MEM-side outputs and the hazard-detection feedback (dest_EXE, WB_EN_EXE, MEM_R_EN_EXE).

Parameters:
DATA_W, 16, operand/result width
ADDR_W, 4, register-file address width
CMD_W, 4, EXE_CMD width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; the block resets asynchronously when rst is low (active-low)
flush  in  1  branch taken; load bubble into ID/EXE
freeze  in  1  hazard detected in ID; load bubble into ID/EXE
forward_EN  in  1  forwarding enable
WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, is_imm_in  in  1 each  ID control
EXE_CMD_in  in  CMD_W  operation
src1_in, src2_in, dest_in  in  ADDR_W each  register addresses
val1_in, val2_in, st_val_in  in  DATA_W each  operands / store data
dest_MEM, dest_WB  in  ADDR_W each  downstream destinations
WB_EN_MEM, WB_EN_WB  in  1 each  downstream write enables
alu_res_MEM, writeVal_WB  in  DATA_W each  forwardable values
busy  out  1  multiplier running; upstream must hold IF/ID
alu_res, st_val  out  DATA_W each  registered result / store data
dest_EXE  out  ADDR_W  registered dest (also to hazard unit)
WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN  out  1 each  registered control
flagZ  out  1  registered zero flag

Behaviour:
- Reset (rst low, async): ID/EXE register, output register, multiplier state all 0. busy=0, flagZ=0, all outputs 0. A reset mid-multiply aborts it; no result is produced.
- ID/EXE load on each edge with busy=0:
  - flush or freeze high: bubble (all control 0, EXE_CMD=NOP).
  - Otherwise: capture all *_in.
  - busy=1: ID/EXE holds.
- EXE_CMD: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR logical, 8 MUL, 9 CMP (SUB, result discarded), 10–15 treated as NOP.
  - Shifts use opB[3:0].
  - ADD/SUB/MUL truncate to DATA_W; carry is ignored.
- Forwarding, applied when forward_EN=1 and the src is nonzero:
  - opA/opB use alu_res_MEM if WB_EN_MEM and dest_MEM==src.
  - Else writeVal_WB if WB_EN_WB and dest_WB==src.
  - MEM has priority over WB.
  - opB forwarding is suppressed when is_imm=1 (val2 used directly).
  - st_val forwards through the same rule against src2 regardless of is_imm.
- Single-cycle ops: result and control appear on outputs one edge after ID/EXE load (latency 1 in stage).
- flagZ update:
  - Updated with (result==0) for ADD/SUB/AND/OR/XOR/SHL/SHR/CMP.
  - Held for NOP and bubbles.
  - For MUL, updated on completion.
- CMP: output control forced to WB_EN=0, MEM_*=0.
- MUL FSM, states IDLE, RUN, DONE:
  - IDLE→RUN when a MUL sits in ID/EXE. Latch forwarded operands; busy=1 from that edge; counter=DATA_W.
  - RUN: each cycle, if multiplier LSB then acc+=multiplicand; multiplicand<<=1; multiplier>>=1; counter-=1. Output register holds a bubble.
  - RUN→DONE when counter reaches 0.
  - DONE: output register loads acc, dest, and control; busy deasserts the same edge; →IDLE.
  - Total: DATA_W+1 edges from ID/EXE load to result on outputs.
  - Operands are latched at RUN entry, so forwarding inputs changing during RUN have no effect.
  - flush/freeze during busy are ignored; ID/EXE holds. Upstream guarantees a MUL already in EXE is never flushed.
- Outputs change only on clk edges or reset.

Test Plan:
1. Reset low mid-operation → all outputs 0, busy=0 immediately (async). Release, ADD val1=3 val2=4 → next edge alu_res=7, flagZ=0.
2. SUB 5−5 with WB_EN_in=1, dest=2 → alu_res=0, flagZ=1, dest_EXE=2, WB_EN_EXE=1. CMP 5−5 → flagZ=1, WB_EN_EXE=0.
3. Forwarding on, src1=3, and both dest_MEM=3 (alu_res_MEM=0x11) and dest_WB=3 (writeVal_WB=0x22), ADD val2=1 → alu_res=0x12. With forward_EN=0 → val1+1. With src1=0 → no forwarding.
4. MUL 0x0012×0x0034 → busy high for 16 cycles, bubbles on outputs; result 0x03A8 appears on edge 17 after load; busy falls that edge; following instruction executes next.
5. freeze=1 then flush=1 with valid ADD inputs → two bubbles: WB_EN_EXE=0, MEM_R_EN_EXE=0, flagZ unchanged.
6. MUL 0xFFFF×0x0002 → alu_res=0xFFFE (truncated). Assert rst low at RUN cycle 8 → busy=0, outputs 0; no result after release.

Source files
------------

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register plus execute datapath.
// Forwarding, single-cycle ALU and an iterative shift-add multiplier.
module id_exe_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              forward_EN,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              is_imm_in,
  input  logic [CMD_W-1:0]  EXE_CMD_in,
  input  logic [ADDR_W-1:0] src1_in,
  input  logic [ADDR_W-1:0] src2_in,
  input  logic [ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [ADDR_W-1:0] dest_MEM,
  input  logic [ADDR_W-1:0] dest_WB,
  input  logic              WB_EN_MEM,
  input  logic              WB_EN_WB,
  input  logic [DATA_W-1:0] alu_res_MEM,
  input  logic [DATA_W-1:0] writeVal_WB,
  output logic              busy,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [ADDR_W-1:0] dest_EXE,
  output logic              WB_EN_EXE,
  output logic              MEM_R_EN_EXE,
  output logic              MEM_W_EN,
  output logic              flagZ
);

  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [CMD_W-1:0] C_ADD = CMD_W'(1);
  localparam logic [CMD_W-1:0] C_SUB = CMD_W'(2);
  localparam logic [CMD_W-1:0] C_AND = CMD_W'(3);
  localparam logic [CMD_W-1:0] C_OR  = CMD_W'(4);
  localparam logic [CMD_W-1:0] C_XOR = CMD_W'(5);
  localparam logic [CMD_W-1:0] C_SHL = CMD_W'(6);
  localparam logic [CMD_W-1:0] C_SHR = CMD_W'(7);
  localparam logic [CMD_W-1:0] C_MUL = CMD_W'(8);
  localparam logic [CMD_W-1:0] C_CMP = CMD_W'(9);

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic              mw;
    logic              imm;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] stv;
  } idex_t;

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic              mw;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] stv;
  } exo_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_e;

  idex_t ie_q, ie_in;
  exo_t  out_q, out_d, sc_o, mo_q, mo_d;
  st_e   st_q, st_d;
  logic  z_q, z_d;
  logic  [CW-1:0] cnt_q, cnt_d;
  logic  [DATA_W-1:0] mc_q, mc_d, mp_q, mp_d, acc_q, acc_d, step;
  logic  [DATA_W-1:0] opa, opb, fw2, stv_f, res;
  logic  hm1, hw1, hm2, hw2, zupd, is_mul, is_cmp;

  assign ie_in = '{wb: WB_EN_in, mr: MEM_R_EN_in, mw: MEM_W_EN_in,
                   imm: is_imm_in, cmd: EXE_CMD_in, src1: src1_in,
                   src2: src2_in, dest: dest_in, val1: val1_in,
                   val2: val2_in, stv: st_val_in};

  // MEM wins over WB; register 0 is never forwarded
  assign hm1 = forward_EN && ie_q.src1 != '0 && WB_EN_MEM && dest_MEM == ie_q.src1;
  assign hw1 = forward_EN && ie_q.src1 != '0 && WB_EN_WB && dest_WB == ie_q.src1;
  assign hm2 = forward_EN && ie_q.src2 != '0 && WB_EN_MEM && dest_MEM == ie_q.src2;
  assign hw2 = forward_EN && ie_q.src2 != '0 && WB_EN_WB && dest_WB == ie_q.src2;

  assign opa   = hm1 ? alu_res_MEM : hw1 ? writeVal_WB : ie_q.val1;
  assign fw2   = hm2 ? alu_res_MEM : hw2 ? writeVal_WB : ie_q.val2;
  assign opb   = ie_q.imm ? ie_q.val2 : fw2;
  assign stv_f = hm2 ? alu_res_MEM : hw2 ? writeVal_WB : ie_q.stv;

  assign is_mul = ie_q.cmd == C_MUL;
  assign is_cmp = ie_q.cmd == C_CMP;
  assign step   = acc_q + (mp_q[0] ? mc_q : '0);

  always_comb begin
    res  = '0;
    zupd = 1'b0;
    unique case (ie_q.cmd)
      C_ADD: begin res = opa + opb; zupd = 1'b1; end
      C_SUB: begin res = opa - opb; zupd = 1'b1; end
      C_AND: begin res = opa & opb; zupd = 1'b1; end
      C_OR:  begin res = opa | opb; zupd = 1'b1; end
      C_XOR: begin res = opa ^ opb; zupd = 1'b1; end
      C_SHL: begin res = opa << opb[3:0]; zupd = 1'b1; end
      C_SHR: begin res = opa >> opb[3:0]; zupd = 1'b1; end
      C_CMP: begin res = opa - opb; zupd = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    sc_o = '0;
    if (!is_mul) begin
      sc_o.res  = res;
      sc_o.stv  = stv_f;
      sc_o.dest = ie_q.dest;
      if (!is_cmp) begin
        sc_o.wb = ie_q.wb;
        sc_o.mr = ie_q.mr;
        sc_o.mw = ie_q.mw;
      end
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    mo_d  = mo_q;
    out_d = '0;
    z_d   = z_q;
    unique case (st_q)
      IDLE: begin
        out_d = sc_o;
        if (zupd) z_d = (res == '0);
        if (is_mul) begin
          st_d      = RUN;
          mc_d      = opa;
          mp_d      = opb;
          acc_d     = '0;
          cnt_d     = CW'(DATA_W);
          mo_d      = '0;
          mo_d.wb   = ie_q.wb;
          mo_d.mr   = ie_q.mr;
          mo_d.mw   = ie_q.mw;
          mo_d.dest = ie_q.dest;
          mo_d.stv  = stv_f;
        end
      end
      RUN: begin
        acc_d = step;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(2)) st_d = DONE;
      end
      DONE: begin
        // last partial product is folded straight into the output
        out_d     = mo_q;
        out_d.res = step;
        z_d       = (step == '0);
        cnt_d     = '0;
        st_d      = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q  <= '0;
      out_q <= '0;
      mo_q  <= '0;
      st_q  <= IDLE;
      z_q   <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
    end else begin
      if (st_q == IDLE) ie_q <= (flush || freeze) ? '0 : ie_in;
      out_q <= out_d;
      mo_q  <= mo_d;
      st_q  <= st_d;
      z_q   <= z_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
    end
  end

  assign busy         = st_q != IDLE;
  assign alu_res      = out_q.res;
  assign st_val       = out_q.stv;
  assign dest_EXE     = out_q.dest;
  assign WB_EN_EXE    = out_q.wb;
  assign MEM_R_EN_EXE = out_q.mr;
  assign MEM_W_EN     = out_q.mw;
  assign flagZ        = z_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: directed vectors, expectations queued
// per due cycle and checked by an independent negedge monitor.
module tb_id_exe_stage;

  localparam int CR = 1, CS = 2, CD = 4, CWB = 8;
  localparam int CMR = 16, CMW = 32, CZ = 64, CB = 128;
  localparam int CCTL = CWB | CMR | CMW;
  localparam int CALU = CR | CD | CCTL | CZ | CB;
  localparam int CALL = CALU | CS;
  localparam int CBUB = CCTL | CZ | CB;

  localparam logic [3:0] NOP = 0, ADD = 1, SUB = 2, AND = 3, OR = 4;
  localparam logic [3:0] XOR = 5, SHL = 6, SHR = 7, MUL = 8, CMP = 9;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] stv;
    logic [3:0]  dest;
    logic        wb, mr, mw, z, busy;
  } exp_t;

  logic clk, rst, flush, freeze, forward_EN;
  logic WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, is_imm_in;
  logic [3:0] EXE_CMD_in, src1_in, src2_in, dest_in;
  logic [15:0] val1_in, val2_in, st_val_in;
  logic [3:0] dest_MEM, dest_WB;
  logic WB_EN_MEM, WB_EN_WB;
  logic [15:0] alu_res_MEM, writeVal_WB;
  logic busy, WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN, flagZ;
  logic [15:0] alu_res, st_val;
  logic [3:0] dest_EXE;

  logic p_en, p_wm, p_ww;
  logic [3:0] p_dm, p_dw;
  logic [15:0] p_am, p_aw;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int q_due[$];
  int q_c[$];
  string q_nm[$];
  exp_t q_e[$];

  id_exe_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .forward_EN(forward_EN), .WB_EN_in(WB_EN_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .is_imm_in(is_imm_in), .EXE_CMD_in(EXE_CMD_in),
    .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
    .val1_in(val1_in), .val2_in(val2_in), .st_val_in(st_val_in),
    .dest_MEM(dest_MEM), .dest_WB(dest_WB),
    .WB_EN_MEM(WB_EN_MEM), .WB_EN_WB(WB_EN_WB),
    .alu_res_MEM(alu_res_MEM), .writeVal_WB(writeVal_WB),
    .busy(busy), .alu_res(alu_res), .st_val(st_val),
    .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE),
    .MEM_R_EN_EXE(MEM_R_EN_EXE), .MEM_W_EN(MEM_W_EN), .flagZ(flagZ)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    while (q_due.size() != 0 && q_due[0] <= cyc) begin
      exp_t e;
      int c;
      string nm;
      logic ok;
      void'(q_due.pop_front());
      e = q_e.pop_front();
      c = q_c.pop_front();
      nm = q_nm.pop_front();
      ok = 1'b1;
      if ((c & CR) != 0 && alu_res !== e.res) ok = 1'b0;
      if ((c & CS) != 0 && st_val !== e.stv) ok = 1'b0;
      if ((c & CD) != 0 && dest_EXE !== e.dest) ok = 1'b0;
      if ((c & CWB) != 0 && WB_EN_EXE !== e.wb) ok = 1'b0;
      if ((c & CMR) != 0 && MEM_R_EN_EXE !== e.mr) ok = 1'b0;
      if ((c & CMW) != 0 && MEM_W_EN !== e.mw) ok = 1'b0;
      if ((c & CZ) != 0 && flagZ !== e.z) ok = 1'b0;
      if ((c & CB) != 0 && busy !== e.busy) ok = 1'b0;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s @%0d: got res=%h stv=%h dest=%h wb=%b mr=%b mw=%b z=%b busy=%b want res=%h stv=%h dest=%h wb=%b mr=%b mw=%b z=%b busy=%b care=%h",
          nm, cyc, alu_res, st_val, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
          MEM_W_EN, flagZ, busy, e.res, e.stv, e.dest, e.wb, e.mr,
          e.mw, e.z, e.busy, c[7:0]);
      end
    end
  end

  task automatic ex(input int due, input string nm,
                    input logic [15:0] r, input logic [15:0] s,
                    input logic [3:0] d, input logic wb, input logic mr,
                    input logic mw, input logic z, input logic b,
                    input int care);
    exp_t e;
    int i;
    e = '{res: r, stv: s, dest: d, wb: wb, mr: mr, mw: mw, z: z, busy: b};
    i = 0;
    while (i < q_due.size() && q_due[i] <= due) i++;
    q_due.insert(i, due);
    q_e.insert(i, e);
    q_c.insert(i, care);
    q_nm.insert(i, nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    forward_EN  = p_en;
    WB_EN_MEM   = p_wm;
    dest_MEM    = p_dm;
    alu_res_MEM = p_am;
    WB_EN_WB    = p_ww;
    dest_WB     = p_dw;
    writeVal_WB = p_aw;
  endtask

  // forwarding environment seen by the instruction issued alongside it
  task automatic env(input logic en, input logic wm, input logic [3:0] dm,
                     input logic [15:0] am, input logic ww,
                     input logic [3:0] dw, input logic [15:0] aw);
    p_en = en; p_wm = wm; p_dm = dm; p_am = am;
    p_ww = ww; p_dw = dw; p_aw = aw;
  endtask

  task automatic drv(input logic [3:0] cmd, input logic wb, input logic mr,
                     input logic mw, input logic imm,
                     input logic [3:0] s1, input logic [3:0] s2,
                     input logic [3:0] d, input logic [15:0] v1,
                     input logic [15:0] v2, input logic [15:0] sv);
    EXE_CMD_in = cmd; WB_EN_in = wb; MEM_R_EN_in = mr; MEM_W_EN_in = mw;
    is_imm_in = imm; src1_in = s1; src2_in = s2; dest_in = d;
    val1_in = v1; val2_in = v2; st_val_in = sv;
  endtask

  task automatic alu(input string nm, input logic [3:0] cmd, input logic wb,
                     input logic [3:0] d, input logic [15:0] v1,
                     input logic [15:0] v2, input logic [15:0] er,
                     input logic ewb, input logic ez, input int care);
    drv(cmd, wb, 0, 0, 1, 0, 0, d, v1, v2, 0);
    ex(cyc + 2, nm, er, 0, d, ewb, 0, 0, ez, 0, care);
    tick();
  endtask

  initial begin
    int k;
    rst = 0; flush = 0; freeze = 0;
    env(0, 0, 0, 0, 0, 0, 0);
    forward_EN = 0; WB_EN_MEM = 0; dest_MEM = 0; alu_res_MEM = 0;
    WB_EN_WB = 0; dest_WB = 0; writeVal_WB = 0;
    drv(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    ex(cyc, "reset_state", 0, 0, 0, 0, 0, 0, 0, 0, CALL);

    rst = 1;
    alu("add_1_1", ADD, 1, 5, 16'h1, 16'h1, 16'h2, 1, 0, CALU);
    alu("add_5_6", ADD, 1, 6, 16'h5, 16'h6, 16'hb, 1, 0, CALU);
    drv(ADD, 1, 1, 1, 1, 0, 0, 7, 16'h7, 16'h8, 16'h55);
    tick();
    drv(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    ex(cyc, "async_reset", 0, 0, 0, 0, 0, 0, 0, 0, CALL);
    tick();
    rst = 1;
    alu("add_3_4", ADD, 1, 1, 16'h3, 16'h4, 16'h7, 1, 0, CALU);

    alu("sub_eq", SUB, 1, 2, 16'h5, 16'h5, 16'h0, 1, 1, CALU);
    alu("cmp_eq", CMP, 1, 3, 16'h5, 16'h5, 16'h0, 0, 1, CBUB);
    alu("add_1_2", ADD, 0, 0, 16'h1, 16'h2, 16'h3, 0, 0, CALU);
    alu("cmp_z", CMP, 1, 3, 16'h7, 16'h7, 16'h0, 0, 1, CBUB);
    alu("and_0", AND, 1, 4, 16'hf0, 16'h0f, 16'h0, 1, 1, CALU);
    alu("nop_hold", NOP, 0, 0, 16'h1, 16'h1, 16'h0, 0, 1, CWB | CZ | CB);
    alu("or_ff", OR, 1, 4, 16'hf0, 16'h0f, 16'hff, 1, 0, CALU);
    alu("xor_0", XOR, 1, 4, 16'haa, 16'haa, 16'h0, 1, 1, CALU);
    alu("shl_mask", SHL, 1, 4, 16'h1, 16'h14, 16'h10, 1, 0, CALU);
    alu("shr_log", SHR, 1, 4, 16'h8000, 16'hf, 16'h1, 1, 0, CALU);

    env(1, 1, 3, 16'h11, 1, 3, 16'h22);
    drv(ADD, 1, 0, 0, 1, 3, 0, 6, 16'h40, 16'h1, 0);
    ex(cyc + 2, "fwd_mem_prio", 16'h12, 0, 6, 1, 0, 0, 0, 0, CALU);
    tick();
    drv(ADD, 1, 0, 0, 1, 0, 0, 6, 16'h40, 16'h1, 0);
    ex(cyc + 2, "fwd_src0", 16'h41, 0, 6, 1, 0, 0, 0, 0, CALU);
    tick();
    env(0, 1, 3, 16'h11, 1, 3, 16'h22);
    drv(ADD, 1, 0, 0, 1, 3, 0, 6, 16'h40, 16'h1, 0);
    ex(cyc + 2, "fwd_off", 16'h41, 0, 6, 1, 0, 0, 0, 0, CALU);
    tick();
    env(1, 0, 3, 16'h11, 1, 3, 16'h22);
    drv(ADD, 1, 0, 0, 1, 3, 0, 6, 16'h40, 16'h1, 0);
    ex(cyc + 2, "fwd_wb", 16'h23, 0, 6, 1, 0, 0, 0, 0, CALU);
    tick();
    env(1, 1, 5, 16'h11, 1, 3, 16'h22);
    drv(ADD, 1, 0, 0, 0, 0, 5, 6, 16'h1, 16'h40, 0);
    ex(cyc + 2, "fwd_opb", 16'h12, 0, 6, 1, 0, 0, 0, 0, CALU);
    tick();
    drv(ADD, 0, 0, 1, 1, 0, 5, 0, 16'h2, 16'h3, 16'h99);
    ex(cyc + 2, "fwd_store", 16'h5, 16'h11, 0, 0, 0, 1, 0, 0, CALL);
    tick();

    env(0, 0, 0, 0, 0, 0, 0);
    k = cyc;
    drv(MUL, 1, 0, 0, 0, 0, 0, 4, 16'h12, 16'h34, 0);
    ex(k + 2, "mul_start", 0, 0, 0, 0, 0, 0, 0, 1, CBUB);
    ex(k + 10, "mul_run", 0, 0, 0, 0, 0, 0, 0, 1, CBUB);
    ex(k + 17, "mul_last", 0, 0, 0, 0, 0, 0, 0, 1, CBUB);
    ex(k + 18, "mul_res", 16'h03a8, 0, 4, 1, 0, 0, 0, 0, CALU);
    tick();
    drv(ADD, 1, 0, 0, 1, 0, 0, 8, 16'h2, 16'h2, 0);
    ex(k + 19, "after_mul", 16'h4, 0, 8, 1, 0, 0, 0, 0, CALU);
    tick();
    drv(ADD, 1, 0, 0, 1, 0, 0, 9, 16'h9, 16'h9, 0);
    ex(k + 20, "held_instr", 16'h12, 0, 9, 1, 0, 0, 0, 0, CALU);
    repeat (17) tick();

    alu("sub_3_3", SUB, 1, 3, 16'h3, 16'h3, 16'h0, 1, 1, CALU);
    freeze = 1;
    drv(ADD, 1, 1, 0, 1, 0, 0, 5, 16'h1, 16'h2, 0);
    ex(cyc + 2, "freeze_bub", 0, 0, 0, 0, 0, 0, 1, 0, CBUB);
    tick();
    freeze = 0; flush = 1;
    ex(cyc + 2, "flush_bub", 0, 0, 0, 0, 0, 0, 1, 0, CBUB);
    tick();
    flush = 0;
    alu("add_resume", ADD, 1, 5, 16'h1, 16'h2, 16'h3, 1, 0, CALU);

    k = cyc;
    drv(MUL, 1, 0, 0, 0, 0, 0, 10, 16'hffff, 16'h2, 0);
    ex(k + 2, "mul2_start", 0, 0, 0, 0, 0, 0, 0, 1, CBUB);
    ex(k + 18, "mul_trunc", 16'hfffe, 0, 10, 1, 0, 0, 0, 0, CALU);
    tick();
    drv(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (18) tick();

    k = cyc;
    drv(MUL, 1, 0, 0, 0, 0, 0, 11, 16'h3, 16'h5, 0);
    ex(k + 2, "mul3_start", 0, 0, 0, 0, 0, 0, 0, 1, CBUB);
    ex(k + 9, "mul3_run", 0, 0, 0, 0, 0, 0, 0, 1, CBUB);
    tick();
    drv(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (9) tick();
    rst = 0;
    ex(cyc, "mul_abort", 0, 0, 0, 0, 0, 0, 0, 0, CALL);
    tick();
    rst = 1;
    ex(k + 18, "no_result_a", 0, 0, 0, 0, 0, 0, 0, 0, CBUB | CD);
    ex(k + 19, "no_result_b", 0, 0, 0, 0, 0, 0, 0, 0, CBUB | CD);
    repeat (11) tick();

    if (q_due.size() != 0) begin
      $display("FAIL drain: got %0d unchecked, want 0", q_due.size());
      total += q_due.size();
      bad += q_due.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
